// File: rtl/gravity_pkg.sv
// Shared types and stand-height helpers for the gravity controller.
// Heights are returned as plain ints; callers size them to their height width.
package gravity_pkg;

    typedef enum logic [1:0] {
        GROUNDED = 2'd0,
        AIRBORNE = 2'd1,
        DEAD     = 2'd2
    } state_e;

    function automatic int stand_dn(int k, int offset, int spacing);
        return offset + k * spacing;
    endfunction

    function automatic int stand_up(int k, int offset, int spacing);
        return offset + k * spacing;
    endfunction

endpackage

// File: rtl/gravity_controller_if.sv
// Frame-tick/button inputs and player-state outputs of the gravity controller.
// The game side drives through master; the controller sits on slave.
interface gravity_controller_if #(
    parameter int LINE_COUNT = 3,
    parameter int H_W        = 9
);
    localparam int LW = (LINE_COUNT > 1) ? $clog2(LINE_COUNT) : 1;

    logic                  tick;
    logic                  switch;
    logic                  is_dead;
    logic [LINE_COUNT-1:0] lines;
    logic                  dir;
    logic [H_W-1:0]        height;
    logic                  grounded;
    logic [LW-1:0]         line_idx;
    logic                  flip;
    logic                  fell_out;

    modport master (
        output tick, switch, is_dead, lines,
        input  dir, height, grounded, line_idx, flip, fell_out
    );

    modport slave (
        input  tick, switch, is_dead, lines,
        output dir, height, grounded, line_idx, flip, fell_out
    );

endinterface

// File: rtl/gravity_controller_landing.sv
// Picks the line crossed by one fall step: nearest below when rising in height,
// nearest above when dropping. Purely combinational.
module line_landing_finder
    import gravity_pkg::*;
#(
    parameter int LINE_COUNT = 3,
    parameter int H_W        = 9,
    parameter int SPACING    = 120,
    parameter int DN_OFFSET  = 120,
    parameter int UP_OFFSET  = 60,
    localparam int LW = (LINE_COUNT > 1) ? $clog2(LINE_COUNT) : 1
) (
    input  logic [H_W-1:0]        height_i,
    input  logic [H_W:0]          nxt_i,
    input  logic                  uflow_i,
    input  logic                  dir_i,
    input  logic [LINE_COUNT-1:0] lines_i,
    output logic                  hit_o,
    output logic [LW-1:0]         idx_o
);

    logic [LINE_COUNT-1:0] dn_ok;
    logic [LINE_COUNT-1:0] up_ok;
    logic [H_W:0]          h_ext;

    assign h_ext = {1'b0, height_i};

    for (genvar k = 0; k < LINE_COUNT; k++) begin : g_line
        localparam logic [H_W:0] DN =
            (H_W+1)'(stand_dn(k, DN_OFFSET, SPACING));
        localparam logic [H_W:0] UP =
            (H_W+1)'(stand_up(k, UP_OFFSET, SPACING));

        assign dn_ok[k] = lines_i[k] && (h_ext < DN) && (DN <= nxt_i);
        // A borrowed step lies below every line, so only the upper bound matters
        assign up_ok[k] = lines_i[k] && (uflow_i || (nxt_i <= UP))
                          && (UP < h_ext);
    end

    always_comb begin
        hit_o = 1'b0;
        idx_o = '0;
        if (!dir_i) begin
            for (int k = LINE_COUNT - 1; k >= 0; k--) begin
                if (dn_ok[k]) begin
                    hit_o = 1'b1;
                    idx_o = LW'(k);
                end
            end
        end else begin
            for (int k = 0; k < LINE_COUNT; k++) begin
                if (up_ok[k]) begin
                    hit_o = 1'b1;
                    idx_o = LW'(k);
                end
            end
        end
    end

endmodule

// File: rtl/gravity_controller.sv
// Player gravity direction and height: flip requests with cooldown,
// per-tick fall integration, landing on enabled lines, out-of-bounds death.
module gravity_controller
    import gravity_pkg::*;
#(
    parameter int LINE_COUNT = 3,
    parameter int H_W        = 9,
    parameter int SPACING    = 120,
    parameter int DN_OFFSET  = 120,
    parameter int UP_OFFSET  = 60,
    parameter int FALL_STEP  = 4,
    parameter int COOLDOWN   = 8,
    parameter int H_MIN      = 0,
    parameter int H_MAX      = 479,
    parameter int START_LINE = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    gravity_controller_if.slave  bus
);

    localparam int LW = (LINE_COUNT > 1) ? $clog2(LINE_COUNT) : 1;
    localparam int CW = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;

    localparam logic [H_W-1:0] H_START =
        H_W'(stand_dn(START_LINE, DN_OFFSET, SPACING));
    localparam logic [H_W:0] STEP = (H_W+1)'(FALL_STEP);

    state_e         state_q;
    logic           dir_q;
    logic [H_W-1:0] h_q;
    logic [LW-1:0]  idx_q;
    logic [CW-1:0]  cd_q;
    logic           sw_q;
    logic           flip_q;
    logic           fell_q;

    logic [H_W:0]   nxt;
    logic           uflow;
    logic           hit;
    logic [LW-1:0]  hit_idx;
    logic           flip_ok;
    logic [H_W-1:0] land_h;

    always_comb begin
        nxt     = dir_q ? ({1'b0, h_q} - STEP) : ({1'b0, h_q} + STEP);
        uflow   = dir_q && ({1'b0, h_q} < STEP);
        flip_ok = bus.switch && !sw_q && (state_q == GROUNDED)
                  && (cd_q == '0) && !bus.is_dead;
        land_h  = dir_q ? H_W'(stand_up(int'(hit_idx), UP_OFFSET, SPACING))
                        : H_W'(stand_dn(int'(hit_idx), DN_OFFSET, SPACING));
    end

    line_landing_finder #(
        .LINE_COUNT (LINE_COUNT),
        .H_W        (H_W),
        .SPACING    (SPACING),
        .DN_OFFSET  (DN_OFFSET),
        .UP_OFFSET  (UP_OFFSET)
    ) u_finder (
        .height_i (h_q),
        .nxt_i    (nxt),
        .uflow_i  (uflow),
        .dir_i    (dir_q),
        .lines_i  (bus.lines),
        .hit_o    (hit),
        .idx_o    (hit_idx)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= GROUNDED;
            dir_q   <= 1'b0;
            h_q     <= H_START;
            idx_q   <= LW'(START_LINE);
            cd_q    <= '0;
            sw_q    <= 1'b0;
            flip_q  <= 1'b0;
            fell_q  <= 1'b0;
        end else begin
            sw_q   <= bus.switch;
            flip_q <= 1'b0;
            fell_q <= 1'b0;
            if (!bus.is_dead) begin
                // An accepted flip swallows a coincident tick entirely
                if (flip_ok) begin
                    dir_q   <= ~dir_q;
                    state_q <= AIRBORNE;
                    cd_q    <= CW'(COOLDOWN);
                    flip_q  <= 1'b1;
                end else if (bus.tick) begin
                    if (cd_q != '0) cd_q <= cd_q - 1'b1;
                    unique case (state_q)
                        GROUNDED: begin
                            if (!bus.lines[idx_q]) state_q <= AIRBORNE;
                        end
                        AIRBORNE: begin
                            if (hit) begin
                                h_q     <= land_h;
                                idx_q   <= hit_idx;
                                state_q <= GROUNDED;
                            end else if (!dir_q
                                         && nxt >= (H_W+1)'(H_MAX)) begin
                                h_q     <= H_W'(H_MAX);
                                state_q <= DEAD;
                                fell_q  <= 1'b1;
                            end else if (dir_q && (uflow
                                         || nxt <= (H_W+1)'(H_MIN))) begin
                                h_q     <= H_W'(H_MIN);
                                state_q <= DEAD;
                                fell_q  <= 1'b1;
                            end else begin
                                h_q <= nxt[H_W-1:0];
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    assign bus.dir      = dir_q;
    assign bus.height   = h_q;
    assign bus.grounded = (state_q == GROUNDED);
    assign bus.line_idx = idx_q;
    assign bus.flip     = flip_q;
    assign bus.fell_out = fell_q;

endmodule

// File: tb/tb_gravity_controller.sv
// Directed game scenarios followed by random play, each cycle compared
// against a height/direction model built from the game rules.
module tb_gravity_controller;

    localparam int LC   = 3;
    localparam int HW   = 9;
    localparam int SP   = 120;
    localparam int DNO  = 120;
    localparam int UPO  = 60;
    localparam int FS   = 4;
    localparam int CD   = 8;
    localparam int HMIN = 0;
    localparam int HMAX = 479;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    gravity_controller_if #(.LINE_COUNT(LC), .H_W(HW)) bus();

    gravity_controller dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int failures = 0;

    // model: st 0 grounded, 1 airborne, 2 dead
    int m_dir, m_h, m_st, m_idx, m_cd, m_sw, m_flip, m_fell;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_fall();
        int nh;
        int hk;
        int s;
        nh = (m_dir != 0) ? m_h - FS : m_h + FS;
        hk = -1;
        if (m_dir == 0) begin
            for (int k = 0; k < LC; k++) begin
                s = DNO + k * SP;
                if (hk < 0 && bus.lines[k] && m_h < s && s <= nh) hk = k;
            end
        end else begin
            for (int k = LC - 1; k >= 0; k--) begin
                s = UPO + k * SP;
                if (hk < 0 && bus.lines[k] && nh <= s && s < m_h) hk = k;
            end
        end
        if (hk >= 0) begin
            m_h   = (m_dir != 0) ? UPO + hk * SP : DNO + hk * SP;
            m_idx = hk;
            m_st  = 0;
        end else if (m_dir == 0 && nh >= HMAX) begin
            m_h = HMAX; m_st = 2; m_fell = 1;
        end else if (m_dir != 0 && nh <= HMIN) begin
            m_h = HMIN; m_st = 2; m_fell = 1;
        end else begin
            m_h = nh;
        end
    endtask

    task automatic model_step();
        if (!rst_n) begin
            m_dir = 0; m_h = DNO; m_st = 0; m_idx = 0;
            m_cd = 0; m_sw = 0; m_flip = 0; m_fell = 0;
            return;
        end
        m_flip = 0;
        m_fell = 0;
        if (!bus.is_dead) begin
            if (bus.switch && m_sw == 0 && m_st == 0 && m_cd == 0) begin
                m_dir  = 1 - m_dir;
                m_st   = 1;
                m_cd   = CD;
                m_flip = 1;
            end else if (bus.tick) begin
                if (m_cd > 0) m_cd--;
                if (m_st == 0) begin
                    if (!bus.lines[m_idx]) m_st = 1;
                end else if (m_st == 1) begin
                    model_fall();
                end
            end
        end
        m_sw = int'(bus.switch);
    endtask

    task automatic cyc();
        model_step();
        @(posedge clk);
        #1;
        check("dir", bus.dir, m_dir);
        check("height", bus.height, m_h);
        check("grounded", bus.grounded, (m_st == 0) ? 1 : 0);
        check("line_idx", bus.line_idx, m_idx);
        check("flip", bus.flip, m_flip);
        check("fell_out", bus.fell_out, m_fell);
    endtask

    task automatic do_tick();
        bus.tick = 1'b1;
        cyc();
        bus.tick = 1'b0;
        cyc();
    endtask

    task automatic pulse_switch();
        bus.switch = 1'b1;
        cyc();
        bus.switch = 1'b0;
    endtask

    task automatic do_reset(logic [LC-1:0] l);
        rst_n = 1'b0;
        bus.lines = l;
        bus.tick = 1'b0;
        bus.switch = 1'b0;
        bus.is_dead = 1'b0;
        cyc();
        cyc();
        rst_n = 1'b1;
    endtask

    initial begin
        bus.tick = 1'b0;
        bus.switch = 1'b0;
        bus.is_dead = 1'b0;
        bus.lines = 3'b111;

        // reset state
        do_reset(3'b111);
        check("rst_dir", bus.dir, 0);
        check("rst_height", bus.height, 120);
        check("rst_grounded", bus.grounded, 1);
        check("rst_idx", bus.line_idx, 0);
        check("rst_flip", bus.flip, 0);

        // flip up, land on line 0 at 60 after 15 ticks
        bus.lines = 3'b011;
        pulse_switch();
        check("flip_pulse", bus.flip, 1);
        check("flip_dir", bus.dir, 1);
        for (int i = 0; i < 3; i++) do_tick();
        pulse_switch();
        check("early_flip_ignored", bus.flip, 0);
        check("early_flip_dir", bus.dir, 1);
        for (int i = 0; i < 11; i++) do_tick();
        check("pre_land_h", bus.height, 64);
        check("pre_land_gnd", bus.grounded, 0);
        do_tick();
        check("land_h", bus.height, 60);
        check("land_gnd", bus.grounded, 1);
        check("land_idx", bus.line_idx, 0);
        pulse_switch();
        check("late_flip", bus.flip, 1);
        check("late_flip_dir", bus.dir, 0);
        for (int i = 0; i < 15; i++) do_tick();
        check("reland_h", bus.height, 120);
        check("reland_gnd", bus.grounded, 1);

        // fall off the bottom with no lines
        do_reset(3'b111);
        bus.lines = 3'b000;
        do_tick();
        check("no_line_air", bus.grounded, 0);
        check("no_line_h", bus.height, 120);
        for (int i = 0; i < 89; i++) do_tick();
        check("fall_h476", bus.height, 476);
        bus.tick = 1'b1;
        cyc();
        bus.tick = 1'b0;
        check("fell_pulse", bus.fell_out, 1);
        check("fell_h", bus.height, 479);
        cyc();
        check("fell_once", bus.fell_out, 0);
        pulse_switch();
        check("dead_no_flip", bus.flip, 0);
        check("dead_dir", bus.dir, 0);
        do_tick();
        check("dead_h", bus.height, 479);

        // is_dead freezes everything
        do_reset(3'b111);
        bus.is_dead = 1'b1;
        bus.lines = 3'b000;
        for (int i = 0; i < 20; i++) begin
            bus.switch = ~bus.switch;
            do_tick();
        end
        check("frozen_gnd", bus.grounded, 1);
        check("frozen_h", bus.height, 120);
        check("frozen_dir", bus.dir, 0);
        bus.is_dead = 1'b0;
        bus.lines = 3'b111;
        bus.switch = 1'b0;
        cyc();
        pulse_switch();
        check("resume_flip", bus.flip, 1);

        // flip and tick in the same cycle
        do_reset(3'b111);
        bus.switch = 1'b1;
        bus.tick = 1'b1;
        cyc();
        bus.switch = 1'b0;
        bus.tick = 1'b0;
        check("sim_dir", bus.dir, 1);
        check("sim_h", bus.height, 120);
        check("sim_flip", bus.flip, 1);
        for (int i = 0; i < 15; i++) do_tick();
        check("sim_land", bus.height, 60);

        // random play
        do_reset(3'b111);
        for (int n = 0; n < 4000; n++) begin
            rst_n = ($urandom_range(0, 399) != 0);
            bus.tick = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 3) == 0) bus.switch = ~bus.switch;
            bus.is_dead = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 39) == 0)
                bus.lines = LC'($urandom_range(0, 7));
            cyc();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
